// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS32 sequencer: opcodes, ALU codes,
// FSM states, error codes and the registered control bundle.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_ILLEGAL     = 2'd1,
        ERR_OVERFLOW    = 2'd2,
        ERR_MEM_TIMEOUT = 2'd3
    } err_t;

    // Static datapath selects plus instruction-class flags used by the FSM.
    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    shamt_sel;
        alu_op_t alu_ctrl;
        logic    mem2reg;
        logic    sign_ext_mode;
        logic    is_lw;
        logic    is_sw;
        logic    is_beq;
        logic    is_bne;
        logic    is_j;
        logic    is_halt;
        logic    ovf_chk;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decoder: maps a MIPS32 word to the control bundle
// and flags opcodes/functs outside the supported subset.
module mc_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_fields;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign unused_fields = ^instr[25:6];

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_dst = 1'b1;
                ctrl.mem2reg = 1'b1;
                case (fn)
                    FN_ADD: begin
                        ctrl.alu_ctrl = ALU_ADD;
                        ctrl.ovf_chk  = 1'b1;
                    end
                    FN_SUB: begin
                        ctrl.alu_ctrl = ALU_SUB;
                        ctrl.ovf_chk  = 1'b1;
                    end
                    FN_AND: ctrl.alu_ctrl = ALU_AND;
                    FN_OR:  ctrl.alu_ctrl = ALU_OR;
                    FN_XOR: ctrl.alu_ctrl = ALU_XOR;
                    FN_NOR: ctrl.alu_ctrl = ALU_NOR;
                    FN_SLT: ctrl.alu_ctrl = ALU_SLT;
                    FN_SLL: begin
                        ctrl.alu_ctrl  = ALU_SLL;
                        ctrl.shamt_sel = 1'b1;
                    end
                    FN_SRL: begin
                        ctrl.alu_ctrl  = ALU_SRL;
                        ctrl.shamt_sel = 1'b1;
                    end
                    FN_SRA: begin
                        ctrl.alu_ctrl  = ALU_SRA;
                        ctrl.shamt_sel = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                ctrl.alu_src       = 1'b1;
                ctrl.sign_ext_mode = 1'b1;
                ctrl.mem2reg       = 1'b1;
                ctrl.alu_ctrl      = ALU_ADD;
                ctrl.ovf_chk       = 1'b1;
            end
            OP_ANDI: begin
                ctrl.alu_src  = 1'b1;
                ctrl.mem2reg  = 1'b1;
                ctrl.alu_ctrl = ALU_AND;
            end
            OP_ORI: begin
                ctrl.alu_src  = 1'b1;
                ctrl.mem2reg  = 1'b1;
                ctrl.alu_ctrl = ALU_OR;
            end
            OP_LW: begin
                ctrl.alu_src       = 1'b1;
                ctrl.sign_ext_mode = 1'b1;
                ctrl.alu_ctrl      = ALU_ADD;
                ctrl.is_lw         = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src       = 1'b1;
                ctrl.sign_ext_mode = 1'b1;
                ctrl.alu_ctrl      = ALU_ADD;
                ctrl.is_sw         = 1'b1;
            end
            OP_BEQ: begin
                ctrl.sign_ext_mode = 1'b1;
                ctrl.alu_ctrl      = ALU_SUB;
                ctrl.is_beq        = 1'b1;
            end
            OP_BNE: begin
                ctrl.sign_ext_mode = 1'b1;
                ctrl.alu_ctrl      = ALU_SUB;
                ctrl.is_bne        = 1'b1;
            end
            OP_J:    ctrl.is_j    = 1'b1;
            OP_HALT: ctrl.is_halt = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer for the MIPS32 datapath: FETCH/DECODE/EXEC/MEM/WB with
// a dmem_ready stall, halt/error reporting and a saturating retired counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      instr,
    input  logic             overflow,
    input  logic             isZero,
    input  logic             dmem_ready,
    output logic             regDst,
    output logic             regWrite,
    output logic             signExtSrc,
    output logic             aluSrc,
    output logic             shamtSel,
    output logic [3:0]       aluControl,
    output logic             memWrite,
    output logic             memRead,
    output logic             mem2reg,
    output logic             sign_ext_mode,
    output logic             pcSrc,
    output logic             pc_en,
    output logic             ir_en,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_dbg
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state_q, state_d;
    err_t               err_q, err_d;
    ctrl_t              ctrl_q, dec_ctrl;
    logic               dec_illegal;
    logic [WAIT_W-1:0]  wait_q;
    logic [CNT_W-1:0]   retired_q;
    logic               taken;
    logic               mem_timeout;

    mc_decoder u_decoder (
        .instr   (instr),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign taken       = (ctrl_q.is_beq && isZero) || (ctrl_q.is_bne && !isZero);
    assign mem_timeout = (wait_q == WAIT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            err_q     <= ERR_NONE;
            ctrl_q    <= CTRL_NOP;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == ST_DECODE) begin
                ctrl_q <= dec_ctrl;
            end
            if (state_q == ST_MEM) begin
                wait_q <= wait_q + 1'b1;
            end else begin
                wait_q <= '0;
            end
            if (pc_en && (retired_q != '1)) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        regWrite   = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        pcSrc      = 1'b0;
        signExtSrc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_en   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    err_d   = ERR_ILLEGAL;
                    state_d = ST_HALTED;
                end else if (dec_ctrl.is_halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ctrl_q.is_beq || ctrl_q.is_bne) begin
                    pc_en   = 1'b1;
                    pcSrc   = taken;
                    state_d = ST_FETCH;
                end else if (ctrl_q.is_j) begin
                    pc_en      = 1'b1;
                    pcSrc      = 1'b1;
                    signExtSrc = 1'b1;
                    state_d    = ST_FETCH;
                end else if (ctrl_q.ovf_chk && overflow) begin
                    err_d   = ERR_OVERFLOW;
                    state_d = ST_HALTED;
                end else if (ctrl_q.is_lw || ctrl_q.is_sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                // The timeout cycle drops the request before dmem_ready is honoured.
                if (mem_timeout) begin
                    err_d   = ERR_MEM_TIMEOUT;
                    state_d = ST_HALTED;
                end else begin
                    memRead  = ctrl_q.is_lw;
                    memWrite = ctrl_q.is_sw;
                    if (dmem_ready) begin
                        if (ctrl_q.is_sw) begin
                            pc_en   = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
            end
            ST_WB: begin
                regWrite = 1'b1;
                pc_en    = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALTED: begin
                if (start) begin
                    err_d   = ERR_NONE;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign regDst        = ctrl_q.reg_dst;
    assign aluSrc        = ctrl_q.alu_src;
    assign shamtSel      = ctrl_q.shamt_sel;
    assign aluControl    = ctrl_q.alu_ctrl;
    assign mem2reg       = ctrl_q.mem2reg;
    assign sign_ext_mode = ctrl_q.sign_ext_mode;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign halted        = (state_q == ST_HALTED);
    assign err_code      = err_q;
    assign retired       = retired_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expectations are queued per instruction
// and compared against the DUT outputs cycle by cycle.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int W     = 11 + 9 + CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic overflow = 1'b0;
    logic isZero = 1'b0;
    logic dmem_ready = 1'b0;
    logic [31:0] instr = 32'h0;

    logic regDst, regWrite, signExtSrc, aluSrc, shamtSel;
    logic [3:0] aluControl;
    logic memWrite, memRead, mem2reg, sign_ext_mode, pcSrc, pc_en, ir_en, busy, halted;
    logic [1:0] err_code;
    logic [CNT_W-1:0] retired;
    logic [2:0] state_dbg;

    mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .overflow(overflow),
        .isZero(isZero), .dmem_ready(dmem_ready), .regDst(regDst), .regWrite(regWrite),
        .signExtSrc(signExtSrc), .aluSrc(aluSrc), .shamtSel(shamtSel),
        .aluControl(aluControl), .memWrite(memWrite), .memRead(memRead),
        .mem2reg(mem2reg), .sign_ext_mode(sign_ext_mode), .pcSrc(pcSrc), .pc_en(pc_en),
        .ir_en(ir_en), .busy(busy), .halted(halted), .err_code(err_code),
        .retired(retired), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: expected output vector, compare mask and per-cycle inputs
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  msk_q[$];
    logic [36:0]   in_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CNT_W-1:0] ret_model = '0;
    string         tag = "reset";

    // strobes: {ir_en, pc_en, regWrite, memRead, memWrite, pcSrc, signExtSrc, busy, halted, err}
    function automatic logic [10:0] st(input logic ir, input logic pc, input logic rw,
                                       input logic mr, input logic mw, input logic ps,
                                       input logic sx, input logic bz, input logic hl,
                                       input logic [1:0] er);
        return {ir, pc, rw, mr, mw, ps, sx, bz, hl, er};
    endfunction

    // datapath selects: {regDst, aluSrc, shamtSel, mem2reg, sign_ext_mode, aluControl}
    function automatic logic [8:0] dpv(input logic rd, input logic as, input logic sh,
                                       input logic m2r, input logic se, input logic [3:0] alu);
        return {rd, as, sh, m2r, se, alu};
    endfunction

    localparam logic [10:0] S_IDLE  = 11'b000_0000_0000;
    localparam logic [10:0] S_FETCH = 11'b100_0000_1000;
    localparam logic [10:0] S_BUSY  = 11'b000_0000_1000;
    localparam logic [10:0] S_WB    = 11'b011_0000_1000;
    localparam logic [10:0] S_RD    = 11'b000_1000_1000;
    localparam logic [10:0] S_WR    = 11'b000_0100_1000;

    // in = {rst, start, dmem_ready, overflow, isZero}
    task automatic push(input logic [31:0] ins, input logic [4:0] in, input logic [10:0] s,
                        input logic [8:0] dp, input bit use_dp);
        in_q.push_back({ins, in});
        exp_q.push_back({s, dp, ret_model});
        msk_q.push_back(use_dp ? {W{1'b1}} : {11'h7FF, 9'h000, {CNT_W{1'b1}}});
        if (in[4]) ret_model = '0;
        else if (s[9] && (ret_model != '1)) ret_model = ret_model + 1'b1;
    endtask

    // driver/compare loop; entered and left at posedge + 1
    task automatic drain();
        logic [36:0]  in;
        logic [W-1:0] e, m, obs;
        while (in_q.size() > 0) begin
            in = in_q.pop_front();
            e  = exp_q.pop_front();
            m  = msk_q.pop_front();
            instr = in[36:5];
            rst = in[4];
            start = in[3];
            dmem_ready = in[2];
            overflow = in[1];
            isZero = in[0];
            #1;
            obs = {ir_en, pc_en, regWrite, memRead, memWrite, pcSrc, signExtSrc, busy, halted,
                   err_code, regDst, aluSrc, shamtSel, mem2reg, sign_ext_mode, aluControl, retired};
            checks++;
            assert ((obs & m) === (e & m)) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs & m, e & m);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start = 1'b0;
        dmem_ready = 1'b0;
        overflow = 1'b0;
        isZero = 1'b0;
    endtask

    task automatic chk_state(input logic [2:0] exp_st, input string name);
        checks++;
        assert (state_dbg === exp_st) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", name, state_dbg, exp_st);
        end
    endtask

    task automatic p_start(input logic hl, input logic [1:0] er);
        push(32'h0, 5'b01000, {8'b0000_0000, hl, er}, 9'h0, 0);
    endtask

    task automatic p_fd(input logic [31:0] ins, input logic [4:0] in);
        push(ins, in, S_FETCH, 9'h0, 0);
        push(ins, in | 5'b01000, S_BUSY, 9'h0, 0);
    endtask

    task automatic p_alu(input logic [31:0] ins, input logic [8:0] dp);
        p_fd(ins, 5'b0);
        push(ins, 5'b0, S_BUSY, dp, 1);
        push(ins, 5'b0, S_WB, dp, 1);
    endtask

    task automatic p_br(input logic [31:0] ins, input logic zero, input logic tk);
        p_fd(ins, {4'b0, zero});
        push(ins, {4'b0, zero}, st(0, 1, 0, 0, 0, tk, 0, 1, 0, 2'd0),
             dpv(0, 0, 0, 0, 1, 4'd1), 1);
    endtask

    task automatic p_j(input logic [31:0] ins);
        p_fd(ins, 5'b0);
        push(ins, 5'b0, st(0, 1, 0, 0, 0, 1, 1, 1, 0, 2'd0), 9'h0, 1);
    endtask

    task automatic p_mem(input logic [31:0] ins, input bit is_lw, input int waits);
        logic [8:0] dp;
        dp = dpv(0, 1, 0, 0, 1, 4'd0);
        p_fd(ins, 5'b0);
        push(ins, 5'b0, S_BUSY, dp, 1);
        for (int k = 0; k < waits; k++) push(ins, 5'b0, is_lw ? S_RD : S_WR, dp, 1);
        if (is_lw) begin
            push(ins, 5'b00100, S_RD, dp, 1);
            push(ins, 5'b0, S_WB, dp, 1);
        end else begin
            push(ins, 5'b00100, st(0, 1, 0, 0, 1, 0, 0, 1, 0, 2'd0), dp, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tag = "reset_state";
        chk_state(ST_IDLE, "reset_state_dbg");
        @(posedge clk);
        #1;
        push(32'h0, 5'b0, S_IDLE, 9'h0, 1);
        push(32'h0, 5'b0, S_IDLE, 9'h0, 1);
        drain();

        tag = "add";
        p_start(0, 2'd0);
        p_alu(32'h00221820, dpv(1, 0, 0, 1, 0, 4'd0));
        drain();

        tag = "lw_wait3";
        p_mem(32'h8C040008, 1, 3);
        drain();

        tag = "beq_bne";
        p_br(32'h10220004, 1, 1);
        p_br(32'h14220004, 1, 0);
        p_br(32'h14220004, 0, 1);
        drain();

        tag = "j";
        p_j(32'h08000100);
        drain();

        tag = "alu_mix";
        p_alu(32'h302500FF, dpv(0, 1, 0, 1, 0, 4'd2));
        p_alu(32'h342500FF, dpv(0, 1, 0, 1, 0, 4'd3));
        p_alu(32'h20250001, dpv(0, 1, 0, 1, 1, 4'd0));
        p_alu(32'h00221822, dpv(1, 0, 0, 1, 0, 4'd1));
        p_alu(32'h00221824, dpv(1, 0, 0, 1, 0, 4'd2));
        p_alu(32'h00221825, dpv(1, 0, 0, 1, 0, 4'd3));
        p_alu(32'h00221826, dpv(1, 0, 0, 1, 0, 4'd4));
        p_alu(32'h00221827, dpv(1, 0, 0, 1, 0, 4'd5));
        p_alu(32'h0022182A, dpv(1, 0, 0, 1, 0, 4'd6));
        p_alu(32'h00021900, dpv(1, 0, 1, 1, 0, 4'd7));
        p_alu(32'h00021902, dpv(1, 0, 1, 1, 0, 4'd8));
        p_alu(32'h00021903, dpv(1, 0, 1, 1, 0, 4'd9));
        drain();

        tag = "sw_wait1";
        p_mem(32'hAC040008, 0, 1);
        drain();

        tag = "addi_overflow";
        p_fd(32'h20250001, 5'b0);
        push(32'h20250001, 5'b00010, S_BUSY, dpv(0, 1, 0, 1, 1, 4'd0), 1);
        push(32'h20250001, 5'b0, st(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2), 9'h0, 0);
        p_start(1, 2'd2);
        p_alu(32'h00221820, dpv(1, 0, 0, 1, 0, 4'd0));
        drain();

        tag = "sw_timeout";
        p_fd(32'hAC040008, 5'b0);
        push(32'hAC040008, 5'b0, S_BUSY, 9'h0, 0);
        for (int k = 0; k < 15; k++) push(32'hAC040008, 5'b0, S_WR, 9'h0, 0);
        push(32'hAC040008, 5'b00100, S_BUSY, 9'h0, 0);
        push(32'hAC040008, 5'b0, st(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd3), 9'h0, 0);
        drain();
        chk_state(ST_HALTED, "timeout_state_dbg");

        tag = "illegal_op";
        p_start(1, 2'd3);
        push(32'hF8000000, 5'b0, S_FETCH, 9'h0, 0);
        push(32'hF8000000, 5'b0, S_BUSY, 9'h0, 0);
        push(32'hF8000000, 5'b0, st(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1), 9'h0, 0);
        drain();

        tag = "illegal_funct";
        p_start(1, 2'd1);
        push(32'h00221821, 5'b0, S_FETCH, 9'h0, 0);
        push(32'h00221821, 5'b0, S_BUSY, 9'h0, 0);
        push(32'h00221821, 5'b0, st(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1), 9'h0, 0);
        drain();

        tag = "halt_op";
        p_start(1, 2'd1);
        push(32'hFC000000, 5'b0, S_FETCH, 9'h0, 0);
        push(32'hFC000000, 5'b0, S_BUSY, 9'h0, 0);
        push(32'hFC000000, 5'b0, st(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0), 9'h0, 0);
        drain();
        chk_state(ST_HALTED, "halt_state_dbg");

        tag = "rst_in_mem";
        p_start(1, 2'd0);
        push(32'hAC040008, 5'b0, S_FETCH, 9'h0, 0);
        push(32'hAC040008, 5'b0, S_BUSY, 9'h0, 0);
        push(32'hAC040008, 5'b01000, S_BUSY, dpv(0, 1, 0, 0, 1, 4'd0), 1);
        push(32'hAC040008, 5'b0, S_WR, dpv(0, 1, 0, 0, 1, 4'd0), 1);
        push(32'hAC040008, 5'b10000, S_WR, dpv(0, 1, 0, 0, 1, 4'd0), 1);
        push(32'hAC040008, 5'b0, S_IDLE, 9'h0, 1);
        push(32'hAC040008, 5'b0, S_IDLE, 9'h0, 1);
        drain();
        chk_state(ST_IDLE, "rst_state_dbg");

        tag = "add_after_rst";
        p_start(0, 2'd0);
        p_alu(32'h00221820, dpv(1, 0, 0, 1, 0, 4'd0));
        p_j(32'h08000100);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
